health_tracker: RTL and testbench

Parametrised successor to the two-player health/block status block. Tracks health and block meters for NUM_PLAYERS fighters by detecting entry into hitstun/blockstun in each player's state code. Adds block regeneration, sticky knockout flags, round-over freeze and a synchronous round restart. Sits between the per-player state machines and the HUD/round controller.

---
 rtl/health_tracker.sv | 166 ++++++++++++++++
 tb/tb_health_tracker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/health_tracker.sv
// health_tracker: per-player health/block meters driven by entry into
// hitstun/blockstun, with block regeneration, sticky knockout flags,
// round-over freeze and a synchronous round restart.
// Optional feature macro: GUARD_BREAK_EN (blockstun entry on an empty block
// meter costs one health point when defined; no effect when undefined).
module health_tracker #(
    parameter int NUM_PLAYERS  = 2,
    parameter int STATE_W      = 4,
    parameter int HEALTH_MAX   = 3,
    parameter int BLOCK_MAX    = 3,
    parameter int S_HITSTUN    = 9,
    parameter int S_BLOCKSTUN  = 10,
    parameter int REGEN_CYCLES = 60,
    parameter int MW           = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PLAYERS*STATE_W-1:0] player_state,
    input  logic                           round_start,
    output logic [NUM_PLAYERS*MW-1:0]      health,
    output logic [NUM_PLAYERS*MW-1:0]      block,
    output logic [NUM_PLAYERS-1:0]         ko,
    output logic                           round_over
);

    // Timer only needs to count up to REGEN_CYCLES-1.
    localparam int TW = (REGEN_CYCLES > 1) ? $clog2(REGEN_CYCLES) : 1;

    localparam logic [MW-1:0]      HMAX      = MW'(HEALTH_MAX);
    localparam logic [MW-1:0]      BMAX      = MW'(BLOCK_MAX);
    localparam logic [MW-1:0]      M_ZERO    = {MW{1'b0}};
    localparam logic [MW-1:0]      M_ONE     = MW'(1);
    localparam logic [TW-1:0]      T_ZERO    = {TW{1'b0}};
    localparam logic [TW-1:0]      T_ONE     = TW'(1);
    localparam logic [TW-1:0]      T_LAST    = TW'(REGEN_CYCLES - 1);
    localparam logic [STATE_W-1:0] ST_HIT    = STATE_W'(S_HITSTUN);
    localparam logic [STATE_W-1:0] ST_BLK    = STATE_W'(S_BLOCKSTUN);

    logic [NUM_PLAYERS*STATE_W-1:0] prev_r;
    logic [NUM_PLAYERS*MW-1:0]      health_r;
    logic [NUM_PLAYERS*MW-1:0]      block_r;
    logic [NUM_PLAYERS*TW-1:0]      timer_r;
    logic [NUM_PLAYERS-1:0]         ko_r;
    logic                           round_over_r;

    logic [NUM_PLAYERS*MW-1:0]      health_nxt_s;
    logic [NUM_PLAYERS*MW-1:0]      block_nxt_s;
    logic [NUM_PLAYERS*TW-1:0]      timer_nxt_s;
    logic [NUM_PLAYERS-1:0]         ko_nxt_s;

    genvar g;
    generate
        for (g = 0; g < NUM_PLAYERS; g = g + 1) begin : g_player
            logic [STATE_W-1:0] cur_s;
            logic [STATE_W-1:0] prev_s;
            logic [MW-1:0]      hp_s;
            logic [MW-1:0]      bk_s;
            logic [TW-1:0]      tm_s;
            logic               hit_s;
            logic               blk_s;
            logic               guard_s;
            logic               dec_s;
            logic [MW-1:0]      hp_nxt_s;
            logic [MW-1:0]      bk_nxt_s;
            logic [TW-1:0]      tm_nxt_s;

            assign cur_s  = player_state[g*STATE_W +: STATE_W];
            assign prev_s = prev_r[g*STATE_W +: STATE_W];
            assign hp_s   = health_r[g*MW +: MW];
            assign bk_s   = block_r[g*MW +: MW];
            assign tm_s   = timer_r[g*TW +: TW];

            // Entry edges: stun state now, different state on the previous edge.
            assign hit_s = (cur_s == ST_HIT) && (prev_s != ST_HIT);
            assign blk_s = (cur_s == ST_BLK) && (prev_s != ST_BLK);

`ifdef GUARD_BREAK_EN
            // Blocking with an empty meter breaks the guard and costs health.
            assign guard_s = blk_s && (bk_s == M_ZERO);
`else
            assign guard_s = 1'b0;
`endif

            assign dec_s = hit_s | guard_s;

            // Health next value: saturating decrement on hit or guard break.
            always_comb begin
                hp_nxt_s = hp_s;
                if (dec_s && (hp_s != M_ZERO)) begin
                    hp_nxt_s = hp_s - M_ONE;
                end else begin
                    hp_nxt_s = hp_s;
                end
            end

            // Block meter and regen timer next values.
            always_comb begin
                bk_nxt_s = bk_s;
                tm_nxt_s = tm_s;
                if (blk_s) begin
                    tm_nxt_s = T_ZERO;
                    if (bk_s != M_ZERO) begin
                        bk_nxt_s = bk_s - M_ONE;
                    end else begin
                        bk_nxt_s = bk_s;
                    end
                end else if ((cur_s == ST_BLK) || (bk_s >= BMAX)) begin
                    tm_nxt_s = T_ZERO;
                    bk_nxt_s = bk_s;
                end else if (tm_s == T_LAST) begin
                    tm_nxt_s = T_ZERO;
                    bk_nxt_s = bk_s + M_ONE;
                end else begin
                    tm_nxt_s = tm_s + T_ONE;
                    bk_nxt_s = bk_s;
                end
            end

            assign health_nxt_s[g*MW +: MW] = hp_nxt_s;
            assign block_nxt_s[g*MW +: MW]  = bk_nxt_s;
            assign timer_nxt_s[g*TW +: TW]  = tm_nxt_s;
            assign ko_nxt_s[g]              = ko_r[g] | (hp_nxt_s == M_ZERO);
        end
    endgenerate

    // State register: reset, round restart, freeze, or normal update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r       <= {(NUM_PLAYERS*STATE_W){1'b0}};
            health_r     <= {NUM_PLAYERS{HMAX}};
            block_r      <= {NUM_PLAYERS{BMAX}};
            timer_r      <= {(NUM_PLAYERS*TW){1'b0}};
            ko_r         <= {NUM_PLAYERS{1'b0}};
            round_over_r <= 1'b0;
        end else if (round_start) begin
            // Held stun across the restart must not count as a fresh entry.
            prev_r       <= player_state;
            health_r     <= {NUM_PLAYERS{HMAX}};
            block_r      <= {NUM_PLAYERS{BMAX}};
            timer_r      <= {(NUM_PLAYERS*TW){1'b0}};
            ko_r         <= {NUM_PLAYERS{1'b0}};
            round_over_r <= 1'b0;
        end else if (round_over_r) begin
            // Frozen: meters hold, entry tracking continues.
            prev_r       <= player_state;
            health_r     <= health_r;
            block_r      <= block_r;
            timer_r      <= timer_r;
            ko_r         <= ko_r;
            round_over_r <= round_over_r;
        end else begin
            prev_r       <= player_state;
            health_r     <= health_nxt_s;
            block_r      <= block_nxt_s;
            timer_r      <= timer_nxt_s;
            ko_r         <= ko_nxt_s;
            round_over_r <= |ko_nxt_s;
        end
    end

    assign health     = health_r;
    assign block      = block_r;
    assign ko         = ko_r;
    assign round_over = round_over_r;

endmodule

// File: tb/tb_health_tracker.sv
// Directed self-checking bench for health_tracker (2 players, REGEN_CYCLES=4).
module tb_health_tracker;

    logic        clk;
    logic        rst;
    logic [7:0]  player_state;
    logic        round_start;
    logic [15:0] health;
    logic [15:0] block;
    logic [1:0]  ko;
    logic        round_over;

    int pass_cnt;
    int total_cnt;

    health_tracker #(
        .NUM_PLAYERS (2),
        .STATE_W     (4),
        .HEALTH_MAX  (3),
        .BLOCK_MAX   (3),
        .S_HITSTUN   (9),
        .S_BLOCKSTUN (10),
        .REGEN_CYCLES(4),
        .MW          (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .player_state(player_state),
        .round_start (round_start),
        .health      (health),
        .block       (block),
        .ko          (ko),
        .round_over  (round_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, leaving time just past the last edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] h, input logic [15:0] b,
                             input logic [1:0] k, input logic r);
        check({tag, "_health"}, {16'h0000, health}, {16'h0000, h});
        check({tag, "_block"},  {16'h0000, block},  {16'h0000, b});
        check({tag, "_ko"},     {30'h0, ko},        {30'h0, k});
        check({tag, "_ro"},     {31'h0, round_over}, {31'h0, r});
    endtask

    logic [15:0] gb_health;

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        rst          = 1'b1;
        player_state = 8'h00;
        round_start  = 1'b0;
        #12;
        check_all("in_reset", 16'h0303, 16'h0303, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(2);
        check_all("idle", 16'h0303, 16'h0303, 2'b00, 1'b0);

        // P0 hitstun entry, hold, leave, re-enter.
        player_state = 8'h09;
        step(1);
        check("p0_hit1", {16'h0, health}, 32'h0000_0302);
        step(5);
        check("p0_hold", {16'h0, health}, 32'h0000_0302);
        player_state = 8'h00;
        step(1);
        player_state = 8'h09;
        step(1);
        check("p0_hit2", {16'h0, health}, 32'h0000_0301);
        player_state = 8'h00;
        step(1);

        // P1 blockstun three times, one idle cycle between each.
        player_state = 8'hA0;
        step(1);
        check("p1_blk1", {16'h0, block}, 32'h0000_0203);
        player_state = 8'h00;
        step(1);
        player_state = 8'hA0;
        step(1);
        check("p1_blk2", {16'h0, block}, 32'h0000_0103);
        player_state = 8'h00;
        step(1);
        player_state = 8'hA0;
        step(1);
        check("p1_blk3", {16'h0, block}, 32'h0000_0003);
        player_state = 8'h00;
        step(1);
        player_state = 8'hA0;
        step(1);
`ifdef GUARD_BREAK_EN
        gb_health = 16'h0201;
`else
        gb_health = 16'h0301;
`endif
        check("p1_blk4_health", {16'h0, health}, {16'h0, gb_health});
        check("p1_blk4_block", {16'h0, block}, 32'h0000_0003);

        // Regeneration outside blockstun.
        player_state = 8'h00;
        step(3);
        check("regen_3", {16'h0, block}, 32'h0000_0003);
        step(1);
        check("regen_4", {16'h0, block}, 32'h0000_0103);
        step(4);
        check("regen_8", {16'h0, block}, 32'h0000_0203);

        // Restart, then simultaneous hits to a double KO.
        round_start = 1'b1;
        step(1);
        round_start = 1'b0;
        check_all("restart1", 16'h0303, 16'h0303, 2'b00, 1'b0);
        player_state = 8'h99;
        step(1);
        check("dbl_hit1", {16'h0, health}, 32'h0000_0202);
        player_state = 8'h00;
        step(1);
        player_state = 8'h99;
        step(1);
        check("dbl_hit2", {16'h0, health}, 32'h0000_0101);
        check("dbl_hit2_ko", {30'h0, ko}, 32'h0);
        player_state = 8'h00;
        step(1);
        player_state = 8'h99;
        step(1);
        check_all("dbl_ko", 16'h0000, 16'h0303, 2'b11, 1'b1);

        // Frozen: further blocks change nothing.
        player_state = 8'hAA;
        step(1);
        player_state = 8'h00;
        step(6);
        check_all("frozen", 16'h0000, 16'h0303, 2'b11, 1'b1);

        // Restart with P0 held in hitstun: no decrement afterwards.
        player_state = 8'h09;
        step(1);
        round_start = 1'b1;
        step(1);
        round_start = 1'b0;
        check_all("restart_held", 16'h0303, 16'h0303, 2'b00, 1'b0);
        step(2);
        check("held_after", {16'h0, health}, 32'h0000_0303);

        // Async reset in the middle of regeneration.
        player_state = 8'hA0;
        step(1);
        check("pre_rst_blk", {16'h0, block}, 32'h0000_0203);
        player_state = 8'h00;
        step(2);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 16'h0303, 16'h0303, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(6);
        check("post_rst", {16'h0, block}, 32'h0000_0303);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
